// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module : alu_issue_ctrl_pkg
// Desc   : Shared ALU constants, instruction class/funct encodings and the
//          stage-1 register layout for the ALU issue front end.
// Rev    : 1.0  initial release
//============================================================================
package alu_issue_ctrl_pkg;

    localparam int REG_SIZE    = 32;
    localparam int OPCODE_SIZE = 4;
    localparam int FUNCT_SIZE  = 4;

    localparam logic [OPCODE_SIZE-1:0] ALU_AND = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] ALU_ORR = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] ALU_ADD = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] ALU_SUB = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] ALU_XOR = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] ALU_NOR = 4'd5;
    localparam logic [OPCODE_SIZE-1:0] ALU_LSL = 4'd6;
    localparam logic [OPCODE_SIZE-1:0] ALU_LSR = 4'd7;

    localparam logic [1:0] CLS_REG = 2'd0;
    localparam logic [1:0] CLS_IMM = 2'd1;
    localparam logic [1:0] CLS_BR  = 2'd2;
    localparam logic [1:0] CLS_NOP = 2'd3;

    localparam logic [FUNCT_SIZE-1:0] FUNCT_AND = 4'd0;
    localparam logic [FUNCT_SIZE-1:0] FUNCT_ORR = 4'd1;
    localparam logic [FUNCT_SIZE-1:0] FUNCT_ADD = 4'd2;
    localparam logic [FUNCT_SIZE-1:0] FUNCT_SUB = 4'd3;
    localparam logic [FUNCT_SIZE-1:0] FUNCT_XOR = 4'd4;
    localparam logic [FUNCT_SIZE-1:0] FUNCT_NOR = 4'd5;
    localparam logic [FUNCT_SIZE-1:0] FUNCT_LSL = 4'd6;
    localparam logic [FUNCT_SIZE-1:0] FUNCT_LSR = 4'd7;
    localparam logic [FUNCT_SIZE-1:0] FUNCT_SLT = 4'd8;

    typedef struct packed {
        logic [REG_SIZE-1:0]    a;
        logic [REG_SIZE-1:0]    b;
        logic [OPCODE_SIZE-1:0] op;
        logic [4:0]             rd;
        logic                   err;
        logic                   slt;
    } s1_t;

    // Signed less-than from a - b without needing the overflow flag.
    function automatic logic slt_bit(input logic a_msb, input logic b_msb,
                                     input logic diff_msb);
        return (a_msb ^ b_msb) ? a_msb : diff_msb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_decode.sv
`default_nettype none
//============================================================================
// Module : alu_funct_decode
// Desc   : Combinational class/funct to ALU op map. Macro ALU_ISSUE_SLT_EN
//          enables funct 8 as signed set-less-than.
// Rev    : 1.0  initial release
//============================================================================
module alu_funct_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [1:0]             i_cls,
    input  logic [FUNCT_SIZE-1:0]  i_funct,
    output logic [OPCODE_SIZE-1:0] o_op,
    output logic                   o_b_sel,
    output logic                   o_err,
    output logic                   o_slt
);

    always_comb begin
        o_op    = ALU_AND;
        o_b_sel = 1'b0;
        o_err   = 1'b0;
        o_slt   = 1'b0;
        case (i_cls)
            CLS_NOP: o_err = 1'b1;
            CLS_BR:  o_op  = ALU_SUB;
            default: begin
                o_b_sel = (i_cls == CLS_IMM);
                case (i_funct)
                    FUNCT_AND: o_op = ALU_AND;
                    FUNCT_ORR: o_op = ALU_ORR;
                    FUNCT_ADD: o_op = ALU_ADD;
                    FUNCT_SUB: o_op = ALU_SUB;
                    FUNCT_XOR: o_op = ALU_XOR;
                    FUNCT_NOR: o_op = ALU_NOR;
                    FUNCT_LSL: o_op = ALU_LSL;
                    FUNCT_LSR: o_op = ALU_LSR;
`ifdef ALU_ISSUE_SLT_EN
                    FUNCT_SLT: begin
                        o_op  = ALU_SUB;
                        o_slt = 1'b1;
                    end
`endif
                    default:   o_err = 1'b1;
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
//============================================================================
// Module : alu_issue_ctrl
// Desc   : Two-stage elastic issue/capture pipeline around a combinational
//          ALU. SLT support follows macro ALU_ISSUE_SLT_EN in the decoder.
// Rev    : 1.0  initial release
//============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_class,
    input  logic [FUNCT_SIZE-1:0]  in_funct,
    input  logic [REG_SIZE-1:0]    in_rs1,
    input  logic [REG_SIZE-1:0]    in_rs2,
    input  logic [REG_SIZE-1:0]    in_imm,
    input  logic [4:0]             in_rd,
    output logic [REG_SIZE-1:0]    alu_a,
    output logic [REG_SIZE-1:0]    alu_b,
    output logic [OPCODE_SIZE-1:0] alu_op,
    input  logic [REG_SIZE-1:0]    alu_out,
    input  logic                   alu_zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REG_SIZE-1:0]    out_result,
    output logic                   out_zero,
    output logic [4:0]             out_rd,
    output logic                   out_err,
    output logic [CNT_W-1:0]       op_count
);

    logic                   r_v1;
    logic                   r_v2;
    s1_t                    r_s1;
    logic [REG_SIZE-1:0]    r_result;
    logic                   r_zero;
    logic [4:0]             r_rd;
    logic                   r_err;
    logic [CNT_W-1:0]       r_count;

    logic [OPCODE_SIZE-1:0] w_dec_op;
    logic                   w_dec_b_sel;
    logic                   w_dec_err;
    logic                   w_dec_slt;
    s1_t                    w_s1_next;
    logic                   w_s2_free;
    logic                   w_in_fire;
    logic                   w_s2_load;
    logic                   w_out_fire;
    logic                   w_lt;
    logic [REG_SIZE-1:0]    w_res;
    logic                   w_zero;

    alu_funct_decode u_decode (
        .i_cls   (in_class),
        .i_funct (in_funct),
        .o_op    (w_dec_op),
        .o_b_sel (w_dec_b_sel),
        .o_err   (w_dec_err),
        .o_slt   (w_dec_slt)
    );

    // Flush gates every transfer so nothing moves in the cycle it is seen.
    assign w_s2_free  = !r_v2 || out_ready;
    assign in_ready   = !flush && (!r_v1 || w_s2_free);
    assign w_in_fire  = in_valid && in_ready;
    assign w_s2_load  = !flush && r_v1 && w_s2_free;
    assign w_out_fire = !flush && r_v2 && out_ready;

    always_comb begin
        w_s1_next.a   = in_rs1;
        w_s1_next.b   = w_dec_b_sel ? in_imm : in_rs2;
        w_s1_next.op  = w_dec_op;
        w_s1_next.rd  = in_rd;
        w_s1_next.err = w_dec_err;
        w_s1_next.slt = w_dec_slt;
    end

    assign w_lt = slt_bit(r_s1.a[REG_SIZE-1], r_s1.b[REG_SIZE-1], alu_out[REG_SIZE-1]);

    always_comb begin
        w_res  = alu_out;
        w_zero = alu_zero;
        if (r_s1.err) begin
            w_res = '0;
        end else if (r_s1.slt) begin
            w_res  = {{(REG_SIZE-1){1'b0}}, w_lt};
            w_zero = !w_lt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_s1     <= '0;
            r_s1.op  <= ALU_AND;
        end else if (flush) begin
            r_v1     <= 1'b0;
        end else if (w_in_fire) begin
            r_v1     <= 1'b1;
            r_s1     <= w_s1_next;
        end else if (w_s2_load) begin
            r_v1     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_rd     <= '0;
            r_err    <= 1'b0;
        end else if (flush) begin
            r_v2     <= 1'b0;
        end else if (w_s2_load) begin
            r_v2     <= 1'b1;
            r_result <= w_res;
            r_zero   <= w_zero;
            r_rd     <= r_s1.rd;
            r_err    <= r_s1.err;
        end else if (out_ready) begin
            r_v2     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_out_fire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign alu_a      = r_s1.a;
    assign alu_b      = r_s1.b;
    assign alu_op     = r_s1.op;
    assign out_valid  = r_v2;
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_rd     = r_rd;
    assign out_err    = r_err;
    assign op_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
//============================================================================
// Module : tb_alu_issue_ctrl
// Desc   : Directed/randomised scoreboard bench for alu_issue_ctrl with a
//          behavioural ALU closing the loop.
// Rev    : 1.0  initial release
//============================================================================
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst, flush, in_valid, in_ready;
    logic [1:0]             in_class;
    logic [FUNCT_SIZE-1:0]  in_funct;
    logic [REG_SIZE-1:0]    in_rs1, in_rs2, in_imm;
    logic [4:0]             in_rd;
    logic [REG_SIZE-1:0]    alu_a, alu_b, alu_out;
    logic [OPCODE_SIZE-1:0] alu_op;
    logic                   alu_zero;
    logic                   out_valid, out_ready, out_zero, out_err;
    logic [REG_SIZE-1:0]    out_result;
    logic [4:0]             out_rd;
    logic [CNT_W-1:0]       op_count;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_funct(in_funct), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
        .out_err(out_err), .op_count(op_count)
    );

    // Behavioural ALU driven by the DUT's registered operands.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_ORR: alu_out = alu_a | alu_b;
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_XOR: alu_out = alu_a ^ alu_b;
            ALU_NOR: alu_out = ~(alu_a | alu_b);
            ALU_LSL: alu_out = alu_a << alu_b[4:0];
            ALU_LSR: alu_out = alu_a >> alu_b[4:0];
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   exp_count = 0;
    bit   rand_rdy  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] cls, input logic [3:0] f,
                                   input logic [31:0] a, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic [4:0] rd);
        exp_t        e;
        logic [31:0] b;
        logic [31:0] r;
        logic        illegal;
        b       = (cls == CLS_IMM) ? imm : rs2;
        r       = '0;
        illegal = 1'b0;
        if (cls == CLS_NOP) illegal = 1'b1;
        else if (cls == CLS_BR) r = a - b;
        else begin
            case (f)
                4'd0: r = a & b;
                4'd1: r = a | b;
                4'd2: r = a + b;
                4'd3: r = a - b;
                4'd4: r = a ^ b;
                4'd5: r = ~(a | b);
                4'd6: r = a << b[4:0];
                4'd7: r = a >> b[4:0];
                4'd8: begin
`ifdef ALU_ISSUE_SLT_EN
                    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
                    illegal = 1'b1;
`endif
                end
                default: illegal = 1'b1;
            endcase
        end
        e.result = illegal ? 32'd0 : r;
        e.zero   = (r == 32'd0);
        e.rd     = rd;
        e.err    = illegal;
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop/compare on output transfer.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
            if (rst) exp_count = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_tests++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_output: observed=%0h expected=none", out_result);
                end
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("out_result", out_result, mon_e.result);
                    chk("out_err", out_err, mon_e.err);
                    chk("out_rd", out_rd, mon_e.rd);
                    if (!mon_e.err) chk("out_zero", out_zero, mon_e.zero);
                    exp_count++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_class, in_funct, in_rs1, in_rs2, in_imm, in_rd));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] cls, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd);
        int   n   = 0;
        logic acc = 1'b0;
        in_valid = 1'b1; in_class = cls; in_funct = f;
        in_rs1 = a; in_rs2 = b; in_imm = imm; in_rd = rd;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        in_valid = 1'b0;
        n_tests++;
        assert (acc) else begin
            n_fail++;
            $error("FAIL issue_accept: observed=timeout expected=accept");
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb.size() > 0 && n < 50) begin
            cyc();
            n++;
        end
        cyc();
        chk("drain_empty", 64'(sb.size()), 0);
        chk("op_count", op_count, 64'(exp_count[CNT_W-1:0]));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_out_zero"}, out_zero, 0);
        chk({tag, "_out_rd"}, out_rd, 0);
        chk({tag, "_out_err"}, out_err, 0);
        chk({tag, "_op_count"}, op_count, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_op"}, alu_op, 64'(ALU_AND));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, c, first_block;
        logic        acc, prev_stall;
        logic [31:0] snap_res;
        logic [4:0]  snap_rd;
        logic [CNT_W-1:0] saved;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_class = CLS_REG; in_funct = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_rd = '0;
        repeat (2) cyc();
        @(negedge clk);
        chk_reset("reset");
        cyc();
        rst = 1'b0;

        // ADD with exact 2-cycle latency
        out_ready = 1'b1; in_valid = 1'b1; in_class = CLS_REG; in_funct = 4'd2;
        in_rs1 = 32'd5; in_rs2 = 32'd7; in_rd = 5'd3;
        @(negedge clk);
        chk("add_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_lat1_valid", out_valid, 0);
        chk("add_alu_op", alu_op, 64'(ALU_ADD));
        chk("add_alu_a", alu_a, 5);
        chk("add_alu_b", alu_b, 7);
        cyc();
        @(negedge clk);
        chk("add_lat2_valid", out_valid, 1);
        chk("add_result", out_result, 12);
        cyc();
        @(negedge clk);
        chk("add_op_count", op_count, 1);

        // Branch forces SUB
        cyc();
        issue(CLS_BR, 4'd0, 32'h1234, 32'h1234, 32'h0, 5'd5);
        @(negedge clk);
        chk("br_alu_op", alu_op, 64'(ALU_SUB));
        drain();

        // Back-pressure with 4 back-to-back LSL immediates
        out_ready = 1'b0; k = 0; c = 0; first_block = -1; prev_stall = 1'b0;
        snap_res = '0; snap_rd = '0;
        while (k < 4 && c < 40) begin
            in_valid = 1'b1; in_class = CLS_IMM; in_funct = 4'd6;
            in_rs1 = 32'd1; in_rs2 = 32'hDEAD; in_imm = 32'(k); in_rd = 5'(8 + k);
            out_ready = (c >= 3);
            @(negedge clk);
            if (!in_ready && first_block < 0) first_block = k;
            if (prev_stall) begin
                chk("stall_result", out_result, 64'(snap_res));
                chk("stall_rd", out_rd, 64'(snap_rd));
            end
            prev_stall = out_valid && !out_ready;
            snap_res = out_result; snap_rd = out_rd;
            acc = in_ready;
            cyc();
            if (acc) k++;
            c++;
        end
        in_valid = 1'b0;
        chk("bp_block_after", 64'(first_block), 2);
        chk("bp_all_accepted", 64'(k), 4);
        drain();

        // Illegal funct and funct 8, then SLT operands
        issue(CLS_REG, 4'hF, 32'd3, 32'd5, 32'd0, 5'd7);
        issue(CLS_REG, 4'd8, 32'd3, 32'd5, 32'd0, 5'd8);
        issue(CLS_NOP, 4'd2, 32'd3, 32'd5, 32'd0, 5'd9);
        issue(CLS_REG, 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd10);
        issue(CLS_REG, 4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd11);
        drain();

        // Random mix under random back-pressure
        rand_rdy = 1;
        for (int i = 0; i < 24; i++)
            issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
                  $urandom, $urandom, $urandom, 5'(i));
        rand_rdy = 0;
        drain();

        // Flush with both stages full and a pending input
        out_ready = 1'b0;
        issue(CLS_REG, 4'd2, 32'd10, 32'd20, 32'd0, 5'd1);
        issue(CLS_REG, 4'd2, 32'd30, 32'd40, 32'd0, 5'd2);
        saved = op_count;
        in_valid = 1'b1; in_class = CLS_REG; in_funct = 4'd2; in_rs1 = 32'd1; in_rs2 = 32'd1;
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_op_count", op_count, 64'(saved));
        cyc();
        @(negedge clk);
        chk("flush_v1_cleared", out_valid, 0);
        cyc();

        // Reset mid-stream
        out_ready = 1'b0;
        issue(CLS_IMM, 4'd2, 32'd4, 32'd0, 32'd6, 5'd3);
        issue(CLS_IMM, 4'd2, 32'd4, 32'd0, 32'd7, 5'd4);
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk_reset("midrst");
        cyc();
        rst = 1'b0;
        issue(CLS_REG, 4'd4, 32'hF0F0, 32'h0FF0, 32'd0, 5'd12);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage front end that drives the combinational ALU: accepts decoded instructions over a valid/ready handshake, converts class/funct into the ALU_Op encoding, and registers the A/B operands feeding the ALU.
- Captures ALU_Out/Zero into a result register and presents it to writeback over a second valid/ready handshake.
- Sits between decode and writeback as a 2-stage elastic pipeline with the ALU between stage 1 and stage 2.

Parameters:
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  upstream may transfer when in_valid && in_ready.
- in_class  in  2  CLS_REG / CLS_IMM / CLS_BR / CLS_NOP (package).
- in_funct  in  FUNCT_SIZE  ALU function select.
- in_rs1  in  REG_SIZE  operand 1 value.
- in_rs2  in  REG_SIZE  operand 2 value.
- in_imm  in  REG_SIZE  sign-extended immediate.
- in_rd  in  5  destination register tag.
- alu_a  out  REG_SIZE  to ALU A.
- alu_b  out  REG_SIZE  to ALU B.
- alu_op  out  OPCODE_SIZE  to ALU ALU_Op.
- alu_out  in  REG_SIZE  from ALU ALU_Out.
- alu_zero  in  1  from ALU Zero.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts.
- out_result  out  REG_SIZE  captured result.
- out_zero  out  1  captured Zero flag.
- out_rd  out  5  destination tag.
- out_err  out  1  illegal funct/class flag.
- op_count  out  CNT_W  retired operations.

Behaviour:
- Reset: all stage registers cleared; v1 = v2 = 0; out_valid = 0; out_result = 0; out_zero = 0; out_rd = 0; out_err = 0; op_count = 0; alu_a = 0; alu_b = 0; alu_op = ALU_AND.
- Reset has priority over flush; flush has priority over all transfers.

Stage 1 (decode register):
- Loads on in_valid && in_ready.
- alu_a = rs1.
- alu_b = rs2 for CLS_REG and CLS_BR; imm for CLS_IMM.
- Funct map: 0 AND, 1 ORR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 LSL, 7 LSR.
- CLS_BR forces ALU_SUB regardless of funct.
- CLS_NOP, or a funct outside the map: alu_op = ALU_AND, err bit set, result forced to 0.
- alu_a/alu_b/alu_op are driven directly from stage-1 registers. No combinational path from in_* to alu_*.

Stage 2 (result register):
- Loads when v1 && (!v2 || out_ready).
- Captures alu_out (0 if err), alu_zero, rd, err.

Handshake:
- s2_free = !v2 || out_ready.
- in_ready = !flush && (!v1 || s2_free).
- v1 next: set on input transfer; cleared when stage 1 drains with no new input.
- v2 next: set on stage-2 load; cleared on out_ready with no load.
- Latency is 2 cycles from input transfer to out_valid. Throughput is 1/cycle when out_ready is held high.
- Back-pressure: with out_ready low and both stages full, in_ready = 0 and all registers hold. out_* stays stable while out_valid && !out_ready.

Counters and flush:
- op_count increments on each out_valid && out_ready; wraps 2^CNT_W-1 -> 0.
- flush clears v1 and v2 in the cycle it is sampled. Any input or output transfer in that cycle is dropped; op_count is not incremented.
- Reset or flush mid-operation discards in-flight ops with no partial output.

Optional Feature:
- Macro ALU_ISSUE_SLT_EN.
- Defined: funct 8 = SLT (signed). alu_op = ALU_SUB; stage 2 captures result = {31'b0, lt}, where lt = (a[31]^b[31]) ? a[31] : alu_out[31]; out_zero = (lt == 0).
- Undefined: funct 8 is illegal (err = 1, result 0).

Decomposition:
- Shared constants package (existing constants.svh) gains FUNCT_SIZE = 4, CLS_* encodings, FUNCT_* codes (including FUNCT_SLT = 8), and a stage-1 struct typedef {a, b, op, rd, err, slt}.
- ALU_* and REG_SIZE/OPCODE_SIZE are reused unchanged.
- One natural sub-module: alu_funct_decode, a combinational class/funct -> {op, b_sel, err, slt} map instantiated inside stage 1.

Test Plan:
- CLS_REG ADD, rs1 = 5, rs2 = 7, out_ready = 1 -> out_valid exactly 2 cycles after transfer, out_result = 12, out_zero = 0, op_count = 1.
- CLS_BR, rs1 = rs2 = 0x1234, funct = 0 -> alu_op = ALU_SUB, out_result = 0, out_zero = 1.
- Back-pressure: 4 back-to-back CLS_IMM LSL ops (rs1 = 1, imm = 0..3), out_ready low 3 cycles -> in_ready drops after 2 accepted; results 1, 2, 4, 8 delivered in order with out_* stable while stalled.
- Illegal funct 0xF -> out_err = 1, out_result = 0; with ALU_ISSUE_SLT_EN undefined, funct 8 gives the same response.
- ALU_ISSUE_SLT_EN defined: rs1 = 0xFFFFFFFF (-1), rs2 = 1 -> out_result = 1; rs1 = 1, rs2 = 0xFFFFFFFF -> out_result = 0, out_zero = 1.
- flush with both stages full and in_valid = 1 -> next cycle out_valid = 0, nothing delivered, op_count unchanged; assert rst mid-stream -> all outputs at reset values next cycle.
